seven_bit_serial_subtractor: RTL and testbench

Clocked companion to the push-button 7-bit adder: computes x − y instead of x + y, bit-serially over seven clocks.
- Operands are loaded nibble-wise from the 4-bit switch bank via synchronized push-button edges.
- A start button launches the subtraction; difference and borrow-out are held for LEDs until the next start.
- Sits on the same board I/O (switches, push buttons, LEDs) as the adder lab and reuses its operand-entry convention.

---
 rtl/seven_bit_serial_subtractor_pkg.sv | 35 +++
 rtl/serial_full_subtractor.sv | 17 +
 rtl/seven_bit_serial_subtractor.sv | 276 +++++++++++++++++++++++++++
 tb/tb_seven_bit_serial_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_bit_serial_subtractor_pkg.sv
// Shared definitions for the push-button serial subtractor: FSM state
// encoding, default operand width, nibble field widths and counter sizing.
package seven_bit_serial_subtractor_pkg;

  // Controller states: waiting for operands/start, shifting bits, result strobe
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default operand / difference width
  localparam int WIDTH_DEF = 7;

  // Operand entry fields: low load fills [LO_W-1:0], high load fills the rest
  localparam int LO_W     = 4;
  localparam int HI_W_DEF = WIDTH_DEF - LO_W;

  // Bit counter width for the default width
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  // Button bank: pb[3:0] followed by the start button
  localparam int NUM_BTN   = 5;
  localparam int BTN_X_LO  = 0;
  localparam int BTN_X_HI  = 1;
  localparam int BTN_Y_LO  = 2;
  localparam int BTN_Y_HI  = 3;
  localparam int BTN_START = 4;

  // Counter width able to index WIDTH bit positions (never narrower than 1)
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_full_subtractor.sv
// One-bit full subtractor used by the serial datapath: computes
// xi - yi - bin, giving the difference bit and the borrow into the next bit.
module serial_full_subtractor (
  input  logic xi,
  input  logic yi,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out for a single bit position
  always_comb begin
    d    = xi ^ yi ^ bin;
    bout = (~xi & yi) | (~(xi ^ yi) & bin);
  end

endmodule

// File: rtl/seven_bit_serial_subtractor.sv
// Bit-serial x - y for the push-button lab board.
// Operands are entered nibble-wise from the switch bank with synchronized,
// edge-detected push buttons; a start press shifts the operands LSB first
// through a single full subtractor over WIDTH clocks, then latches the
// difference and borrow for the LEDs.
// Build option: define SUB_DEBOUNCE_EN to insert a per-button debounce filter
// (DEBOUNCE_CYCLES consecutive identical samples) between the synchronizer
// and the edge detector.
module seven_bit_serial_subtractor
  import seven_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       pb,
  input  logic             pb_start,
  input  logic [3:0]       a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int HI_W    = WIDTH - LO_W;
  localparam int CNT_W   = cnt_width(WIDTH);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_edge;

  assign btn_raw = {pb_start, pb};

  // After reset the synchronizers hold zeros that do not reflect the pins.
  // A button may only arm its edge detector once the chain has been refilled
  // with real samples and shows the button released, so a button held
  // through reset release never produces a load.
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               primed;

  assign primed = (prime_q == PRIME_W'(SYNC_STAGES));

  // Count clocks since reset until the synchronizers carry live samples
  always_comb begin
    prime_d = prime_q;
    if (!primed) begin
      prime_d = prime_q + 1'b1;
    end
  end

  // Priming counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q <= '0;
    end else begin
      prime_q <= prime_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   level;
    logic                   prev_q;
    logic                   edge_q, edge_d;
    logic                   armed_q, armed_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Metastability synchronizer chain for the raw button
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= btn_raw[gi];
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

`ifdef SUB_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic            filt_q, filt_d;
    logic [DB_W-1:0] dcnt_q, dcnt_d;

    // Filtered level flips only after DEBOUNCE_CYCLES disagreeing samples in a row
    always_comb begin
      filt_d = filt_q;
      dcnt_d = '0;
      if (sync_lvl != filt_q) begin
        if (dcnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d = ~filt_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    // Debounce filter state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= 1'b0;
        dcnt_q <= '0;
      end else begin
        filt_q <= filt_d;
        dcnt_q <= dcnt_d;
      end
    end

    assign level = filt_q;
`else
    assign level = sync_lvl;
`endif

    // Rising-edge detect on the conditioned level, gated by the arm flag
    always_comb begin
      armed_d = armed_q | (primed & ~sync_lvl);
      edge_d  = level & ~prev_q & armed_q;
    end

    // Edge detector registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q  <= 1'b0;
        edge_q  <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        prev_q  <= level;
        edge_q  <= edge_d;
        armed_q <= armed_d;
      end
    end

    assign btn_edge[gi] = edge_q;
  end

`ifndef SUB_DEBOUNCE_EN
  // The debounce depth only matters when the filter is built in
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_depth_unused
  end
`endif

  // ---------------------------------------------------------------------------
  // Operand registers, serial datapath and controller
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] xw_q, xw_d;
  logic [WIDTH-1:0] yw_q, yw_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [HI_W-1:0]  a_hi;
  logic             start_edge;
  logic             last_bit;
  logic             bit_d;
  logic             bit_bout;

  assign a_hi       = HI_W'(a);
  assign start_edge = btn_edge[BTN_START];
  assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

  serial_full_subtractor u_fsub (
    .xi   (xw_q[0]),
    .yi   (yw_q[0]),
    .bin  (b_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state: start edges outside IDLE are simply dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = SHIFT;
      SHIFT:   if (last_bit)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs decoded from state
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Operand loading and bit-serial subtraction
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    xw_d     = xw_q;
    yw_d     = yw_q;
    res_d    = res_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        // Several simultaneous edges all take the same switch value
        if (btn_edge[BTN_X_LO]) x_d[LO_W-1:0]     = a;
        if (btn_edge[BTN_X_HI]) x_d[WIDTH-1:LO_W] = a_hi;
        if (btn_edge[BTN_Y_LO]) y_d[LO_W-1:0]     = a;
        if (btn_edge[BTN_Y_HI]) y_d[WIDTH-1:LO_W] = a_hi;
        if (start_edge) begin
          xw_d  = x_q;
          yw_d  = y_q;
          res_d = '0;
          b_d   = 1'b0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        xw_d  = xw_q >> 1;
        yw_d  = yw_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        b_d   = bit_bout;
        cnt_d = cnt_q + 1'b1;
        // Publish on the step into DONE so the LEDs change together with done
        if (last_bit) begin
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_bout;
        end
      end
      default: ;
    endcase
  end

  // Operand, working and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      xw_q     <= '0;
      yw_q     <= '0;
      res_q    <= '0;
      b_q      <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      xw_q     <= xw_d;
      yw_q     <= yw_d;
      res_q    <= res_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_seven_bit_serial_subtractor.sv
// Directed bench for the push-button serial subtractor: operand entry,
// start/done timing, dropped inputs while shifting, reset abort and
// held-button behaviour.
module tb_seven_bit_serial_subtractor;

  localparam int W = 7;
`ifdef SUB_DEBOUNCE_EN
  localparam int HOLD    = 24;
  localparam int LAT     = 27;
  localparam int SREL    = 24;
  localparam int INT_ON  = 4;
  localparam int INT_OFF = 24;
`else
  localparam int HOLD    = 6;
  localparam int LAT     = 11;
  localparam int SREL    = 3;
  localparam int INT_ON  = 5;
  localparam int INT_OFF = 9;
`endif

  logic         clk;
  logic         rst_n;
  logic [3:0]   pb;
  logic         pb_start;
  logic [3:0]   a;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;
  logic         done;

  int n_checks;
  int n_pass;

  seven_bit_serial_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pb       (pb),
    .pb_start (pb_start),
    .a        (a),
    .diff     (diff),
    .borrow   (borrow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Press the buttons in mask with switch value val, then release
  task automatic load(input logic [3:0] mask, input logic [3:0] val);
    a  = val;
    pb = mask;
    repeat (HOLD) @(negedge clk);
    pb = 4'b0000;
    repeat (HOLD) @(negedge clk);
  endtask

  // Press start, watch one whole operation window and check its results
  task automatic run_sub(input string tag, input logic [W-1:0] exp_d,
                         input logic exp_b, input bit interfere);
    int lat;
    int busy_n;
    int done_n;
    lat    = 0;
    busy_n = 0;
    done_n = 0;
    pb_start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == SREL) pb_start = 1'b0;
      if (interfere && i == INT_ON) begin
        a        = 4'hF;
        pb[0]    = 1'b1;
        pb_start = 1'b1;
      end
      if (interfere && i == INT_OFF) begin
        pb[0]    = 1'b0;
        pb_start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) lat = i;
      end
    end
    $display("op %s: diff=%02h borrow=%0d latency=%0d busy_cycles=%0d done_pulses=%0d",
             tag, diff, borrow, lat, busy_n, done_n);
    check({tag, " diff"},    32'(diff),   32'(exp_d));
    check({tag, " borrow"},  32'(borrow), 32'(exp_b));
    check({tag, " latency"}, 32'(lat),    32'(LAT));
    check({tag, " busy"},    32'(busy_n), 32'(W));
    check({tag, " done"},    32'(done_n), 32'd1);
  endtask

  initial begin
    int done_n;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    pb       = 4'b0000;
    pb_start = 1'b0;
    a        = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst diff",   32'(diff),   32'd0);
    check("rst borrow", 32'(borrow), 32'd0);
    check("rst busy",   32'(busy),   32'd0);
    check("rst done",   32'(done),   32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0x25 - 0x13
    load(4'b0001, 4'h5);
    load(4'b0010, 4'h2);
    load(4'b0100, 4'h3);
    load(4'b1000, 4'h1);
    run_sub("25-13", 7'h12, 1'b0, 1'b0);

    // 0x05 - 0x09 wraps
    load(4'b0001, 4'h5);
    load(4'b0010, 4'h0);
    load(4'b0100, 4'h9);
    load(4'b1000, 4'h0);
    run_sub("05-09", 7'h7C, 1'b1, 1'b0);

    // Equal full-scale operands
    load(4'b0101, 4'hF);
    load(4'b1010, 4'h7);
    run_sub("7F-7F", 7'h00, 1'b0, 1'b0);

    // Zero minus one
    load(4'b0011, 4'h0);
    load(4'b0100, 4'h1);
    load(4'b1000, 4'h0);
    run_sub("00-01", 7'h7F, 1'b1, 1'b0);

    // Button and start presses while shifting are dropped
    load(4'b0001, 4'h5);
    load(4'b0010, 4'h2);
    load(4'b0100, 4'h3);
    load(4'b1000, 4'h1);
    run_sub("25-13 busy-press", 7'h12, 1'b0, 1'b1);
    run_sub("25-13 again", 7'h12, 1'b0, 1'b0);

    // Reset during the third SHIFT cycle
    pb_start = 1'b1;
    for (int i = 1; i <= LAT - 5; i++) begin
      @(negedge clk);
      if (i == SREL) pb_start = 1'b0;
    end
    check("pre-abort busy", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    pb_start = 1'b0;
    a        = 4'h3;
    pb[2]    = 1'b1;
    #1;
    check("abort diff",   32'(diff),   32'd0);
    check("abort borrow", 32'(borrow), 32'd0);
    check("abort busy",   32'(busy),   32'd0);
    check("abort done",   32'(done),   32'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    done_n = 0;
    // pb2 stays held through reset release
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    check("abort no done", 32'(done_n), 32'd0);
    pb[2] = 1'b0;
    repeat (HOLD) @(negedge clk);
    load(4'b0001, 4'h0);
    load(4'b0010, 4'h4);
    run_sub("40-00 held-y", 7'h40, 1'b0, 1'b0);
    load(4'b0100, 4'h1);
    run_sub("40-01", 7'h3F, 1'b0, 1'b0);

    // Simultaneous presses share one switch value
    load(4'b0101, 4'h7);
    load(4'b0010, 4'h1);
    load(4'b1000, 4'h0);
    run_sub("17-07", 7'h10, 1'b0, 1'b0);

    // Holding pb2 for 50 cycles loads once, at the first edge
    load(4'b0001, 4'hF);
    load(4'b0010, 4'h0);
    load(4'b1000, 4'h0);
    a     = 4'h6;
    pb[2] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i >= HOLD) a = (a == 4'h6) ? 4'h9 : 4'h6;
    end
    pb[2] = 1'b0;
    repeat (HOLD) @(negedge clk);
    run_sub("0F-06 hold", 7'h09, 1'b0, 1'b0);

`ifdef SUB_DEBOUNCE_EN
    // Short glitch on pb2 is filtered out
    a     = 4'hA;
    pb[2] = 1'b1;
    repeat (5) @(negedge clk);
    pb[2] = 1'b0;
    repeat (30) @(negedge clk);
    run_sub("0F-06 glitch", 7'h09, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
